softmax_row_sequencer: RTL

SOFTMAX_ROW_SEQUENCER -- requirements
Module: softmax_row_sequencer

---
 rtl/softmax_row_sequencer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/softmax_row_sequencer.sv
// Softmax row sequencer: walks a block of rows in the output buffer, drives
// each row into the softmax unit for SM_LAT cycles and writes the result back
// to the same address. The current FSM state is exposed on state_dbg.
//
// Handshake: start is a single-cycle request that is only accepted in IDLE;
// buf_rd_data is valid the cycle after buf_rd_en; res_wr_en qualifies
// res_wr_addr/res_wr_data for exactly one cycle per row; done pulses once.
module softmax_row_sequencer #(
  parameter int ARRAYWIDTH = 8,
  parameter int DATASIZE   = 32,
  parameter int ADDR_W     = 6,
  parameter int SM_LAT     = 20
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [ADDR_W-1:0]              base_addr,
  input  logic [ADDR_W-1:0]              num_rows,
  output logic                           busy,
  output logic                           done,
  output logic                           buf_rd_en,
  output logic [ADDR_W-1:0]              buf_rd_addr,
  input  logic [ARRAYWIDTH*DATASIZE-1:0] buf_rd_data,
  output logic                           sm_en,
  output logic [ARRAYWIDTH*DATASIZE-1:0] sm_xi,
  input  logic [ARRAYWIDTH*DATASIZE-1:0] sm_out,
  output logic                           res_wr_en,
  output logic [ADDR_W-1:0]              res_wr_addr,
  output logic [ARRAYWIDTH*DATASIZE-1:0] res_wr_data,
  output logic [2:0]                     state_dbg
);

  localparam logic [7:0] RUN_LAST = 8'(SM_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_LOAD  = 3'd2,
    S_RUN   = 3'd3,
    S_WRITE = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  state_t              state, state_n;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W-1:0]   count_q;
  logic [ADDR_W-1:0]   row_idx;
  logic [7:0]          run_cnt;
  logic [ADDR_W-1:0]   cur_addr;
  logic                last_row;

  // Address of the row in flight; wraps naturally at 2^ADDR_W.
  assign cur_addr  = base_q + row_idx;
  assign last_row  = (row_idx == count_q - ADDR_W'(1));
  assign state_dbg = state;

  // State register plus job/row bookkeeping and the softmax input row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      base_q  <= '0;
      count_q <= '0;
      row_idx <= '0;
      run_cnt <= '0;
      sm_xi   <= '0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: begin
          if (start && (num_rows != '0)) begin
            base_q  <= base_addr;
            count_q <= num_rows;
            row_idx <= '0;
          end
        end
        S_LOAD: begin
          sm_xi   <= buf_rd_data;
          run_cnt <= '0;
        end
        S_RUN: begin
          run_cnt <= run_cnt + 8'd1;
        end
        S_WRITE: begin
          if (!last_row) row_idx <= row_idx + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Next-state decode and state-decoded strobes; addresses are zero when idle.
  always_comb begin
    state_n     = state;
    busy        = 1'b0;
    done        = 1'b0;
    buf_rd_en   = 1'b0;
    buf_rd_addr = '0;
    sm_en       = 1'b0;
    res_wr_en   = 1'b0;
    res_wr_addr = '0;
    res_wr_data = '0;
    case (state)
      S_IDLE: begin
        if (start) state_n = (num_rows != '0) ? S_READ : S_FIN;
      end
      S_READ: begin
        busy        = 1'b1;
        buf_rd_en   = 1'b1;
        buf_rd_addr = cur_addr;
        state_n     = S_LOAD;
      end
      S_LOAD: begin
        busy    = 1'b1;
        state_n = S_RUN;
      end
      S_RUN: begin
        busy  = 1'b1;
        sm_en = 1'b1;
        if (run_cnt == RUN_LAST) state_n = S_WRITE;
      end
      S_WRITE: begin
        busy        = 1'b1;
        res_wr_en   = 1'b1;
        res_wr_addr = cur_addr;
        res_wr_data = sm_out;
        state_n     = last_row ? S_FIN : S_READ;
      end
      S_FIN: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule
